// File: rtl/divider_seq_16_bit.sv
// Multi-cycle signed divider: one restoring shift-subtract step per clock on magnitudes,
// followed by a sign fix-up cycle and a one-cycle done pulse.
module divider_seq_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   dvd_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               ovf_pend_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               div_by_zero_reg;
    logic               overflow_reg;

    logic               accept;
    logic               b_is_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    assign accept    = start && (state_reg == IDLE || state_reg == DONE);
    assign b_is_zero = (b == '0);
    // Magnitude of the most negative value wraps to itself, which is the correct unsigned value.
    assign a_mag     = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag     = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign shifted   = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvs_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = b_is_zero ? DONE : CALC;
            CALC:    if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = start ? (b_is_zero ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            rem_reg         <= '0;
            dvd_reg         <= '0;
            dvs_reg         <= '0;
            cnt_reg         <= '0;
            sign_q_reg      <= 1'b0;
            sign_r_reg      <= 1'b0;
            ovf_pend_reg    <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rem_reg      <= '0;
                dvd_reg      <= a_mag;
                dvs_reg      <= b_mag;
                cnt_reg      <= '0;
                sign_q_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
                sign_r_reg   <= a[WIDTH-1];
                ovf_pend_reg <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                // Zero divisor skips the iterations, so results are published right here.
                if (b_is_zero) begin
                    quotient_reg    <= '1;
                    remainder_reg   <= a;
                    div_by_zero_reg <= 1'b1;
                    overflow_reg    <= 1'b0;
                end
            end else if (state_reg == CALC) begin
                if (!trial[WIDTH]) begin
                    rem_reg <= trial;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_reg <= shifted;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
                end
                cnt_reg <= cnt_reg + 1'b1;
            end else if (state_reg == FIX) begin
                quotient_reg    <= sign_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
                remainder_reg   <= sign_r_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];
                div_by_zero_reg <= 1'b0;
                overflow_reg    <= ovf_pend_reg;
            end
        end
    end

    assign busy        = (state_reg == CALC) || (state_reg == FIX);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;
endmodule
